// File: rtl/instruction_register.sv
// Instruction register: captures a RAM instruction word on IR_Load and presents
// it split into opcode and register-address fields, all straight from the held word.
module instruction_register #(
  parameter int INST_WIDTH   = 21,
  parameter int OPCODE_WIDTH = 3,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    IR_Load,
  input  logic [INST_WIDTH-1:0]   Ram_Inst_Out,
  output logic [OPCODE_WIDTH-1:0] Opcode,
  output logic [ADDR_WIDTH-1:0]   Source_Reg1,
  output logic [ADDR_WIDTH-1:0]   Source_Reg2,
  output logic [ADDR_WIDTH-1:0]   Dest_Reg,
  output logic [INST_WIDTH-1:0]   Instruction,
  output logic                    IR_Valid
);

  logic [INST_WIDTH-1:0] inst_q;
  logic                  valid_q;

  // Reset outranks a coincident load so the datapath always restarts from a clean word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (IR_Load) begin
      inst_q  <= Ram_Inst_Out;
      valid_q <= 1'b1;
    end
  end

  assign Opcode      = inst_q[INST_WIDTH-1 -: OPCODE_WIDTH];
  assign Source_Reg1 = inst_q[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign Source_Reg2 = inst_q[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign Dest_Reg    = inst_q[ADDR_WIDTH-1:0];
  assign Instruction = inst_q;
  assign IR_Valid    = valid_q;

endmodule

// File: tb/tb_instruction_register.sv
// Self-checking bench for instruction_register: a reference model pushes expected
// {valid, word} per edge onto a queue, each test pops and compares after the edge.
module tb_instruction_register;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IR_Load;
  logic [20:0] Ram_Inst_Out;
  logic [2:0]  Opcode;
  logic [5:0]  Source_Reg1;
  logic [5:0]  Source_Reg2;
  logic [5:0]  Dest_Reg;
  logic [20:0] Instruction;
  logic        IR_Valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [20:0] m_inst  = '0;
  logic        m_valid = 1'b0;
  logic [21:0] exp_q[$];

  instruction_register dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .IR_Load     (IR_Load),
    .Ram_Inst_Out(Ram_Inst_Out),
    .Opcode      (Opcode),
    .Source_Reg1 (Source_Reg1),
    .Source_Reg2 (Source_Reg2),
    .Dest_Reg    (Dest_Reg),
    .Instruction (Instruction),
    .IR_Valid    (IR_Valid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d passed=%0d", total_cnt, pass_cnt);
    $fatal(1, "watchdog");
  end

  // Drives one edge worth of stimulus and records what the register should hold after it.
  task automatic step(input logic rst, input logic ld, input logic [20:0] d);
    Reset        = rst;
    IR_Load      = ld;
    Ram_Inst_Out = d;
    if (rst) begin
      m_inst  = '0;
      m_valid = 1'b0;
    end else if (ld) begin
      m_inst  = d;
      m_valid = 1'b1;
    end
    exp_q.push_back({m_valid, m_inst});
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] e;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 21'h1FFFFF);
      e = exp_q.pop_front();
      total_cnt++;
      if ({IR_Valid, Instruction} !== e || {Opcode, Source_Reg1, Source_Reg2, Dest_Reg} !== e[20:0]
          || e !== 22'h0)
        $display("FAIL reset[%0d]: got valid=%b inst=%h fields=%h required valid=0 inst=000000",
                 i, IR_Valid, Instruction, {Opcode, Source_Reg1, Source_Reg2, Dest_Reg});
      else pass_cnt++;
    end
  endtask

  task automatic test_single_load();
    logic [21:0] e;
    step(1'b0, 1'b1, 21'b101_000011_000101_111111);
    e = exp_q.pop_front();
    total_cnt++;
    if ({IR_Valid, Instruction} !== e || Opcode !== 3'b101 || Source_Reg1 !== 6'b000011
        || Source_Reg2 !== 6'b000101 || Dest_Reg !== 6'b111111 || IR_Valid !== 1'b1)
      $display("FAIL single_load: got op=%b s1=%b s2=%b d=%b valid=%b required op=101 s1=000011 s2=000101 d=111111 valid=1",
               Opcode, Source_Reg1, Source_Reg2, Dest_Reg, IR_Valid);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    logic [21:0] e;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 21'h0);
      // Mid-cycle wiggling of the strobe-less inputs must not reach the register.
      Ram_Inst_Out = 21'($urandom);
      e = exp_q.pop_front();
      total_cnt++;
      if ({IR_Valid, Instruction} !== e || {Opcode, Source_Reg1, Source_Reg2, Dest_Reg} !== e[20:0])
        $display("FAIL hold[%0d]: got valid=%b inst=%h required valid=%b inst=%h",
                 i, IR_Valid, Instruction, e[21], e[20:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e;
    logic [20:0] words[3];
    words[0] = 21'h000001;
    words[1] = 21'h1FFFFF;
    words[2] = 21'h155555;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, words[i]);
      e = exp_q.pop_front();
      total_cnt++;
      if ({IR_Valid, Instruction} !== e || {Opcode, Source_Reg1, Source_Reg2, Dest_Reg} !== e[20:0])
        $display("FAIL back_to_back[%0d]: got valid=%b inst=%h fields=%h required valid=%b inst=%h",
                 i, IR_Valid, Instruction, {Opcode, Source_Reg1, Source_Reg2, Dest_Reg}, e[21], e[20:0]);
      else pass_cnt++;
    end
    total_cnt++;
    if (Opcode !== 3'b101 || Source_Reg1 !== 6'b010101 || Source_Reg2 !== 6'b010101 || Dest_Reg !== 6'b010101)
      $display("FAIL back_to_back_final: got op=%b s1=%b s2=%b d=%b required op=101 s1=010101 s2=010101 d=010101",
               Opcode, Source_Reg1, Source_Reg2, Dest_Reg);
    else pass_cnt++;
  endtask

  task automatic test_reset_priority();
    logic [21:0] e;
    step(1'b1, 1'b1, 21'h1FFFFF);
    e = exp_q.pop_front();
    total_cnt++;
    if ({IR_Valid, Instruction} !== e || {Opcode, Source_Reg1, Source_Reg2, Dest_Reg} !== 21'h0)
      $display("FAIL reset_priority: got valid=%b inst=%h required valid=0 inst=000000", IR_Valid, Instruction);
    else pass_cnt++;
    // Reset during a hold: previous word stays until the reset edge, then clears.
    step(1'b0, 1'b1, 21'h0ABCDE);
    e = exp_q.pop_front();
    total_cnt++;
    if ({IR_Valid, Instruction} !== e)
      $display("FAIL reload: got valid=%b inst=%h required valid=%b inst=%h", IR_Valid, Instruction, e[21], e[20:0]);
    else pass_cnt++;
    Reset   = 1'b1;
    IR_Load = 1'b0;
    #2;
    total_cnt++;
    if (Instruction !== 21'h0ABCDE || IR_Valid !== 1'b1)
      $display("FAIL reset_before_edge: got valid=%b inst=%h required valid=1 inst=0abcde", IR_Valid, Instruction);
    else pass_cnt++;
    step(1'b1, 1'b0, 21'h0ABCDE);
    e = exp_q.pop_front();
    total_cnt++;
    if ({IR_Valid, Instruction} !== e || {Opcode, Source_Reg1, Source_Reg2, Dest_Reg} !== 21'h0)
      $display("FAIL reset_mid_hold: got valid=%b inst=%h required valid=0 inst=000000", IR_Valid, Instruction);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [21:0] e;
    logic [20:0] w;
    int errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      w = 21'($urandom % 32'd2097152);
      step(1'b0, 1'b1, w);
      e = exp_q.pop_front();
      total_cnt++;
      if ({IR_Valid, Instruction} !== e || {Opcode, Source_Reg1, Source_Reg2, Dest_Reg} !== e[20:0]
          || Instruction !== w) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got inst=%h fields=%h valid=%b required %h valid=1",
                   i, Instruction, {Opcode, Source_Reg1, Source_Reg2, Dest_Reg}, IR_Valid, w);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    Reset        = 1'b1;
    IR_Load      = 1'b0;
    Ram_Inst_Out = '0;
    test_reset();
    test_single_load();
    test_hold();
    test_back_to_back();
    test_reset_priority();
    test_random();
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
